// File: rtl/lfsr_range_rng.sv
// Free-running Fibonacci LFSR that serves unbiased bounded draws in [0, limit)
// using power-of-two masking with rejection sampling.
module lfsr_range_rng #(
  parameter int                WIDTH        = 16,
  parameter logic [WIDTH-1:0]  TAPS         = 16'hB400,
  parameter logic [WIDTH-1:0]  SEED_DEFAULT = 16'h0001,
  parameter int                OUT_WIDTH    = 8,
  parameter int                STRIDE       = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [WIDTH-1:0]     seed,
  input  logic                 seed_load,
  input  logic                 req_valid,
  input  logic [OUT_WIDTH-1:0] req_limit,
  output logic                 req_ready,
  output logic                 out_valid,
  output logic [OUT_WIDTH-1:0] out_data,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     rand_state,
  output logic [7:0]           rejects
);

  localparam int CNT_W = (STRIDE > 1) ? $clog2(STRIDE) : 1;
  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(STRIDE - 1);

  typedef enum logic [1:0] {S_IDLE, S_STRIDE, S_CHECK, S_DONE} fsm_e;

  fsm_e                 fsm_q, fsm_d;
  logic [WIDTH-1:0]     state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [OUT_WIDTH-1:0] limit_q, limit_d;
  logic [OUT_WIDTH-1:0] mask_q, mask_d;
  logic                 out_valid_q, out_valid_d;
  logic [OUT_WIDTH-1:0] out_data_q, out_data_d;
  logic [7:0]           rejects_q, rejects_d;
  logic [OUT_WIDTH-1:0] cand;

  // An all-zero state would lock the register, so it is forced back to 1.
  function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] s);
    if (s == '0) return WIDTH'(1);
    return {s[WIDTH-2:0], ^(s & TAPS)};
  endfunction

  function automatic logic [OUT_WIDTH-1:0] build_mask(input logic [OUT_WIDTH-1:0] lim);
    logic [OUT_WIDTH-1:0] m;
    if (lim == '0) return '1;
    m = lim - OUT_WIDTH'(1);
    for (int i = OUT_WIDTH - 2; i >= 0; i--) m[i] = m[i] | m[i+1];
    return m;
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] r);
    return (r == 8'hFF) ? r : r + 8'd1;
  endfunction

  always_comb begin
    cand        = state_q[OUT_WIDTH-1:0] & mask_q;
    state_d     = seed_load ? ((seed == '0) ? WIDTH'(1) : seed) : lfsr_step(state_q);
    fsm_d       = fsm_q;
    cnt_d       = cnt_q;
    limit_d     = limit_q;
    mask_d      = mask_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    rejects_d   = rejects_q;
    case (fsm_q)
      S_IDLE: begin
        if (req_valid) begin
          limit_d   = req_limit;
          mask_d    = build_mask(req_limit);
          rejects_d = 8'd0;
          cnt_d     = CNT_RELOAD;
          fsm_d     = S_STRIDE;
        end
      end
      S_STRIDE: begin
        if (cnt_q == '0) fsm_d = S_CHECK;
        else             cnt_d = cnt_q - CNT_W'(1);
      end
      S_CHECK: begin
        if ((limit_q == '0) || (cand < limit_q)) begin
          out_data_d  = cand;
          out_valid_d = 1'b1;
          fsm_d       = S_DONE;
        end else begin
          rejects_d = sat_inc(rejects_q);
          cnt_d     = CNT_RELOAD;
          fsm_d     = S_STRIDE;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          fsm_d       = S_IDLE;
        end
      end
      default: fsm_d = S_IDLE;
    endcase
  end

  // Limit, mask and stride counter are only meaningful once a request is latched.
  always_ff @(posedge clock) begin
    cnt_q   <= cnt_d;
    limit_q <= limit_d;
    mask_q  <= mask_d;
    if (!reset) begin
      state_q     <= SEED_DEFAULT;
      fsm_q       <= S_IDLE;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      rejects_q   <= 8'd0;
    end else begin
      state_q     <= state_d;
      fsm_q       <= fsm_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      rejects_q   <= rejects_d;
    end
  end

  assign req_ready  = (fsm_q == S_IDLE);
  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign rand_state = state_q;
  assign rejects    = rejects_q;

endmodule

// File: tb/tb_lfsr_range_rng.sv
// Bench for lfsr_range_rng: an 8-bit STRIDE=1 instance and a default 16-bit
// STRIDE=4 instance, checked against a reference LFSR and a draw scoreboard.
module tb_lfsr_range_rng;

  logic        clock;
  logic        rst_n, seed_load, req_valid, out_ready, sel;
  logic [15:0] seed;
  logic [7:0]  req_limit;
  logic        a_req_valid, b_req_valid;
  logic        a_req_ready, a_out_valid, b_req_ready, b_out_valid;
  logic [7:0]  a_out_data, a_rand_state, a_rejects, b_out_data, b_rejects;
  logic [15:0] b_rand_state;
  logic        v_req_ready, v_out_valid;
  logic [7:0]  v_out_data, v_rejects;
  logic [15:0] v_state;

  logic [15:0] m_a, m_b;
  int          n_checks = 0;
  int          n_pass   = 0;

  typedef struct {
    logic [7:0] data;
    logic [7:0] rej;
    int         lat;
  } exp_t;
  exp_t sb[$];

  logic [7:0] step_tab [8] = '{8'h02, 8'h04, 8'h08, 8'h11, 8'h23, 8'h47, 8'h8E, 8'h1C};

  assign a_req_valid = req_valid && !sel;
  assign b_req_valid = req_valid && sel;
  assign v_req_ready = sel ? b_req_ready : a_req_ready;
  assign v_out_valid = sel ? b_out_valid : a_out_valid;
  assign v_out_data  = sel ? b_out_data  : a_out_data;
  assign v_rejects   = sel ? b_rejects   : a_rejects;
  assign v_state     = sel ? b_rand_state : {8'h00, a_rand_state};

  lfsr_range_rng #(
    .WIDTH(8), .TAPS(8'hB8), .SEED_DEFAULT(8'h01), .OUT_WIDTH(8), .STRIDE(1)
  ) u_dut_a (
    .clock(clock), .reset(rst_n), .seed(seed[7:0]), .seed_load(seed_load),
    .req_valid(a_req_valid), .req_limit(req_limit), .req_ready(a_req_ready),
    .out_valid(a_out_valid), .out_data(a_out_data), .out_ready(out_ready),
    .rand_state(a_rand_state), .rejects(a_rejects)
  );

  lfsr_range_rng #(
    .WIDTH(16), .TAPS(16'hB400), .SEED_DEFAULT(16'h0001), .OUT_WIDTH(8), .STRIDE(4)
  ) u_dut_b (
    .clock(clock), .reset(rst_n), .seed(seed), .seed_load(seed_load),
    .req_valid(b_req_valid), .req_limit(req_limit), .req_ready(b_req_ready),
    .out_valid(b_out_valid), .out_data(b_out_data), .out_ready(out_ready),
    .rand_state(b_rand_state), .rejects(b_rejects)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [15:0] ref_step(input logic [15:0] s, input int w, input logic [15:0] taps);
    logic [15:0] n;
    if (s == 16'h0) return 16'h1;
    n = {s[14:0], ^(s & taps)};
    if (w == 8) n[15:8] = 8'h00;
    return n;
  endfunction

  function automatic exp_t predict(input logic [15:0] s0, input logic [7:0] lim, input logic use_b);
    exp_t e;
    logic [15:0] s;
    int li, mm, stride, w, samples, cand;
    logic [15:0] taps;
    s = s0; li = int'(lim); mm = 0; samples = 0;
    stride = use_b ? 4 : 1;
    w      = use_b ? 16 : 8;
    taps   = use_b ? 16'hB400 : 16'h00B8;
    if (li == 0) mm = 255;
    else while (mm < li - 1) mm = mm * 2 + 1;
    e.rej = 8'd0;
    for (int tries = 0; tries < 5000; tries++) begin
      for (int k = 0; k < stride + 1; k++) s = ref_step(s, w, taps);
      samples++;
      cand = int'(s[7:0]) & mm;
      if (li == 0 || cand < li) begin
        e.data = 8'(cand);
        break;
      end
      if (e.rej != 8'hFF) e.rej = e.rej + 8'd1;
    end
    e.lat = samples * (stride + 1) + 1;
    return e;
  endfunction

  // Inputs are stable across the posedge, so the model sees exactly what the DUTs see.
  task automatic cycle();
    @(posedge clock);
    if (!rst_n) begin
      m_a = 16'h0001;
      m_b = 16'h0001;
    end else if (seed_load) begin
      m_a = (seed[7:0] == 8'h00) ? 16'h0001 : {8'h00, seed[7:0]};
      m_b = (seed == 16'h0) ? 16'h0001 : seed;
    end else begin
      m_a = ref_step(m_a, 8, 16'h00B8);
      m_b = ref_step(m_b, 16, 16'hB400);
    end
    @(negedge clock);
  endtask

  task automatic draw(input logic [7:0] lim, input int hold,
                      output logic [7:0] gd, output logic [7:0] gr, output int gl);
    exp_t e;
    int n;
    logic [7:0] d0;
    n = 0;
    while (!v_req_ready && n < 100) begin cycle(); n++; end
    check_eq("req_ready_before_accept", 32'(v_req_ready), 32'd1);
    sb.push_back(predict(sel ? m_b : m_a, lim, sel));
    out_ready = 1'b0;
    req_valid = 1'b1; req_limit = lim;
    cycle();
    req_valid = 1'b0;
    n = 1;
    while (!v_out_valid && n < 3000) begin cycle(); n++; end
    e = sb.pop_front();
    check_eq("out_valid_arrives", 32'(v_out_valid), 32'd1);
    gd = v_out_data; gr = v_rejects; gl = n;
    check_eq("draw_data", 32'(gd), 32'(e.data));
    check_eq("draw_rejects", 32'(gr), 32'(e.rej));
    check_eq("draw_latency", 32'(gl), 32'(e.lat));
    if (lim != 8'd0) check_eq("draw_in_range", 32'(gd < lim), 32'd1);
    d0 = v_out_data;
    for (int i = 0; i < hold; i++) begin
      cycle();
      check_eq("hold_valid", 32'(v_out_valid), 32'd1);
      check_eq("hold_data", 32'(v_out_data), 32'(d0));
      check_eq("hold_req_ready", 32'(v_req_ready), 32'd0);
      check_eq("hold_state_steps", 32'(v_state), 32'(sel ? m_b : m_a));
    end
    out_ready = 1'b1;
    cycle();
    out_ready = 1'b0;
    check_eq("handoff_valid_low", 32'(v_out_valid), 32'd0);
    check_eq("handoff_req_ready", 32'(v_req_ready), 32'd1);
  endtask

  initial begin
    logic [7:0] gd, gr;
    int gl, distinct, n;
    logic seen [256];
    logic zero_seen;

    sel = 1'b0; rst_n = 1'b0; seed_load = 1'b0; seed = 16'h0;
    req_valid = 1'b0; req_limit = 8'd0; out_ready = 1'b0;
    m_a = 16'h0; m_b = 16'h0;
    @(negedge clock);
    cycle();
    cycle();
    check_eq("rst_req_ready", 32'(a_req_ready), 32'd1);
    check_eq("rst_out_valid", 32'(a_out_valid), 32'd0);
    check_eq("rst_out_data", 32'(a_out_data), 32'd0);
    check_eq("rst_rejects", 32'(a_rejects), 32'd0);
    check_eq("rst_state_a", 32'(a_rand_state), 32'h01);
    check_eq("rst_state_b", 32'(b_rand_state), 32'h0001);
    check_eq("rst_req_ready_b", 32'(b_req_ready), 32'd1);
    rst_n = 1'b1;

    seed = 16'h0001; seed_load = 1'b1;
    cycle();
    seed_load = 1'b0;
    check_eq("load_01", 32'(a_rand_state), 32'h01);
    for (int i = 0; i < 8; i++) begin
      cycle();
      check_eq("step_seq", 32'(a_rand_state), 32'(step_tab[i]));
    end

    seed = 16'h0001; seed_load = 1'b1;
    cycle();
    seed_load = 1'b0;
    foreach (seen[i]) seen[i] = 1'b0;
    distinct = 0; zero_seen = 1'b0;
    for (int i = 0; i < 255; i++) begin
      cycle();
      if (a_rand_state == 8'h00) zero_seen = 1'b1;
      if (!seen[a_rand_state]) distinct++;
      seen[a_rand_state] = 1'b1;
    end
    check_eq("period_distinct", 32'(distinct), 32'd255);
    check_eq("period_no_zero", 32'(zero_seen), 32'd0);
    check_eq("period_return", 32'(a_rand_state), 32'h01);

    seed = 16'h0000; seed_load = 1'b1;
    cycle();
    seed_load = 1'b0;
    check_eq("load_zero_a", 32'(a_rand_state), 32'h01);
    check_eq("load_zero_b", 32'(b_rand_state), 32'h0001);

    seed = 16'h0008; seed_load = 1'b1;
    cycle();
    seed_load = 1'b0;
    check_eq("accept_state", 32'(a_rand_state), 32'h08);
    draw(8'd3, 0, gd, gr, gl);
    check_eq("lim3_data", 32'(gd), 32'd2);
    check_eq("lim3_rejects", 32'(gr), 32'd1);
    check_eq("lim3_latency", 32'(gl), 32'd5);

    draw(8'd1, 0, gd, gr, gl);
    check_eq("lim1_data", 32'(gd), 32'd0);
    check_eq("lim1_rejects", 32'(gr), 32'd0);

    seed = 16'h0001; seed_load = 1'b1;
    cycle();
    seed_load = 1'b0;
    draw(8'd0, 0, gd, gr, gl);
    check_eq("lim0_data", 32'(gd), 32'h04);

    draw(8'd100, 10, gd, gr, gl);

    // Reload the LFSR while the draw is in STRIDE; CHECK must sample the new state.
    req_valid = 1'b1; req_limit = 8'd0;
    cycle();
    req_valid = 1'b0;
    seed = 16'h0047; seed_load = 1'b1;
    cycle();
    seed_load = 1'b0;
    n = 0;
    while (!a_out_valid && n < 50) begin cycle(); n++; end
    check_eq("midload_valid", 32'(a_out_valid), 32'd1);
    check_eq("midload_data", 32'(a_out_data), 32'h47);
    check_eq("midload_rejects", 32'(a_rejects), 32'd0);
    out_ready = 1'b1;
    cycle();
    out_ready = 1'b0;

    req_valid = 1'b1; req_limit = 8'd0;
    cycle();
    req_valid = 1'b0;
    cycle();
    rst_n = 1'b0;
    cycle();
    check_eq("midrst_valid", 32'(a_out_valid), 32'd0);
    check_eq("midrst_req_ready", 32'(a_req_ready), 32'd1);
    check_eq("midrst_state", 32'(a_rand_state), 32'h01);
    check_eq("midrst_data", 32'(a_out_data), 32'd0);
    check_eq("midrst_rejects", 32'(a_rejects), 32'd0);
    rst_n = 1'b1;

    sel = 1'b1;
    draw(8'd0, 0, gd, gr, gl);
    draw(8'd1, 0, gd, gr, gl);
    draw(8'd200, 3, gd, gr, gl);

    for (int i = 0; i < 1000; i++) begin
      sel = 1'($urandom_range(0, 1));
      draw(8'($urandom_range(1, 255)), int'($urandom_range(0, 2)), gd, gr, gl);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/lfsr_range_rng.md
Name: lfsr_range_rng

Overview:
- Parametrised Fibonacci LFSR random source for maze generation and gameplay (start cell, wall knock-down direction, enemy moves).
- Runs continuously for timing entropy.
- Serves bounded draws in [0, limit) through a req/ready, valid/ready handshake.
- Uses power-of-two masking with rejection sampling, so draws carry no modulo bias.

Parameters:
- WIDTH, 16, LFSR state width (>=3).
- TAPS, 16'hB400, feedback mask; bit i set means state[i] enters the XOR (default polynomial x^16+x^14+x^13+x^11+1).
- SEED_DEFAULT, 16'h0001, state loaded at reset; must be nonzero.
- OUT_WIDTH, 8, width of limit and out_data (<= WIDTH).
- STRIDE, 4, extra LFSR steps between candidate samples (>=1).

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-low reset
- seed  in  WIDTH  value for seed_load
- seed_load  in  1  load seed into state this cycle
- req_valid  in  1  draw request
- req_limit  in  OUT_WIDTH  exclusive upper bound; 0 means full range 2^OUT_WIDTH
- req_ready  out  1  block can accept a request (FSM in IDLE)
- out_valid  out  1  out_data holds a completed draw
- out_data  out  OUT_WIDTH  drawn value, always < limit (when limit != 0)
- out_ready  in  1  consumer accepts out_data
- rand_state  out  WIDTH  raw LFSR state, registered
- rejects  out  8  saturating count of rejected candidates in current/last draw

Behaviour:
- Reset (reset==0 at a clock edge):
  - state <= SEED_DEFAULT; FSM <= IDLE; out_valid <= 0; out_data <= 0; rejects <= 0.
  - req_ready reads 1 the cycle after reset.
- Step rule, every cycle that is not reset or load:
  - fb = XOR-reduce(state & TAPS)
  - state <= {state[WIDTH-2:0], fb}
- Load:
  - seed_load=1 gives state <= seed, or 1 if seed==0. No step occurs that cycle.
  - Load has priority over stepping, in any FSM state.
- Lock-up guard: if state is ever all-zero, the next value is 1.
- Mask, computed at accept and registered with the limit:
  - limit!=0: mask = (limit-1) with all bits below its MSB set (bit-smear).
  - limit==0: mask = all ones.
  - limit==1 gives mask 0.
- FSM states: IDLE, STRIDE, CHECK, DONE.
- IDLE:
  - req_ready=1.
  - req_valid=1 latches limit and mask, clears rejects, loads counter=STRIDE-1, goes to STRIDE.
- STRIDE: counter decrements each cycle; at counter==0 go to CHECK.
- CHECK:
  - cand = state[OUT_WIDTH-1:0] & mask.
  - If limit==0 or cand<limit: out_data <= cand, out_valid <= 1, go to DONE.
  - Otherwise: rejects <= rejects+1 (saturating at 255), counter reload, go to STRIDE.
- Timing: the sampled state is exactly STRIDE+1 steps after the state present in the accept cycle. Each retry samples a further STRIDE+1 steps later. Minimum accept-to-out_valid latency is STRIDE+2 cycles.
- DONE:
  - out_valid and out_data are held stable until out_valid&&out_ready; then out_valid <= 0 and go to IDLE.
  - req_ready stays 0 until IDLE, so no back-to-back accept in the handoff cycle.
- seed_load mid-draw: the draw continues using the reloaded sequence; FSM state and counters are unaffected.
- Reset mid-draw: the draw is abandoned, with all outputs at their reset values next cycle.
- The LFSR keeps stepping during DONE and IDLE (free-running).

Test Plan:
- Step sequence, WIDTH=8, TAPS=8'hB8: load 8'h01 -> rand_state 01,02,04,08,11,23,47,8E,1C on successive cycles.
- Period and lock-up, same config: from 8'h01, 255 cycles visit 255 distinct nonzero states and return to 01; seed_load with 0 -> rand_state=01.
- Accept, WIDTH=8, OUT_WIDTH=8, STRIDE=1: state 8'h08 at accept, limit 3 -> candidate 23&3=3 rejected; next candidate 8E&3=2 accepted.
  - Expect out_data=2, rejects=1, out_valid 5 cycles after accept.
- Edge limits: limit=1 -> out_data=0, rejects=0; limit=0 from state 8'h01 with STRIDE=1 -> out_data=04.
- Backpressure: hold out_ready=0 for 10 cycles -> out_valid/out_data stable, req_ready=0, rand_state still stepping; out_ready=1 -> out_valid=0 next cycle, req_ready=1.
- Interference: seed_load during STRIDE -> sample taken from the new sequence; reset low during CHECK -> out_valid=0, FSM IDLE, state=SEED_DEFAULT; 1000 random limits 1..255 -> every out_data < limit.
